// File: rtl/game_scoreboard.sv
// Game scoreboard: tallies win/lose pulses per game, latches the game result until
// acknowledged, and logs every scoring event into a small FIFO for a downstream consumer.
module game_scoreboard #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TALLY_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               WINNER,
  input  logic               LOSER,
  input  logic               GAMEOVER,
  input  logic [1:0]         WHO,
  input  logic [3:0]         count,
  input  logic               ack,
  input  logic               evt_ready,
  output logic               evt_valid,
  output logic [5:0]         evt_data,
  output logic               evt_overflow,
  output logic [TALLY_W-1:0] win_tally,
  output logic [TALLY_W-1:0] lose_tally,
  output logic [TALLY_W-1:0] games_played,
  output logic [1:0]         last_who,
  output logic               result_valid
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned EVT_W = 6;

  localparam logic [0:0] ST_PLAY = 1'b0;
  localparam logic [0:0] ST_OVER = 1'b1;

  localparam logic [1:0] EV_WIN  = 2'b01;
  localparam logic [1:0] EV_LOSE = 2'b10;
  localparam logic [1:0] EV_END  = 2'b11;

  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
    return (&v) ? v : v + TALLY_W'(1);
  endfunction

  logic [0:0]         state_q, state_d;
  logic [TALLY_W-1:0] win_q, win_d;
  logic [TALLY_W-1:0] lose_q, lose_d;
  logic [TALLY_W-1:0] games_q, games_d;
  logic [1:0]         who_q, who_d;

  logic               push;
  logic [EVT_W-1:0]   push_data;

  logic [EVT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic               ovf_q, ovf_d;
  logic               full, pop, push_ok;

  // Scoring FSM: GAMEOVER outranks WINNER, which outranks LOSER.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    lose_d    = lose_q;
    games_d   = games_q;
    who_d     = who_q;
    push      = 1'b0;
    push_data = '0;
    case (state_q)
      ST_PLAY: begin
        if (GAMEOVER) begin
          who_d     = WHO;
          games_d   = sat_inc(games_q);
          push      = 1'b1;
          push_data = {EV_END, 2'b00, WHO};
          state_d   = ST_OVER;
        end else if (WINNER) begin
          win_d     = sat_inc(win_q);
          push      = 1'b1;
          push_data = {EV_WIN, count};
        end else if (LOSER) begin
          lose_d    = sat_inc(lose_q);
          push      = 1'b1;
          push_data = {EV_LOSE, count};
        end
      end
      ST_OVER: begin
        if (ack) begin
          win_d   = '0;
          lose_d  = '0;
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_PLAY;
      win_q   <= '0;
      lose_q  <= '0;
      games_q <= '0;
      who_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      games_q <= games_d;
      who_q   <= who_d;
    end
  end

  // Event FIFO: a pop frees a slot in the same cycle, so push-on-full with pop is not a drop.
  always_comb begin
    full    = (occ_q == CNT_W'(FIFO_DEPTH));
    pop     = (occ_q != '0) && evt_ready;
    push_ok = push && (!full || pop);
    ovf_d   = ovf_q | (push && full && !pop);
    occ_d   = occ_q;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  assign evt_valid    = (occ_q != '0);
  assign evt_data     = mem_q[rd_ptr_q];
  assign evt_overflow = ovf_q;
  assign win_tally    = win_q;
  assign lose_tally   = lose_q;
  assign games_played = games_q;
  assign last_who     = who_q;
  assign result_valid = (state_q == ST_OVER);

endmodule

// File: tb/tb_game_scoreboard.sv
// Directed bench for game_scoreboard: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_game_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       WINNER, LOSER, GAMEOVER, ack, evt_ready;
  logic [1:0] WHO;
  logic [3:0] count;
  logic       evt_valid, evt_overflow, result_valid;
  logic [5:0] evt_data;
  logic [7:0] win_tally, lose_tally, games_played;
  logic [1:0] last_who;

  int vectors    = 0;
  int miscompares = 0;

  game_scoreboard #(.FIFO_DEPTH(4), .TALLY_W(8)) dut (
    .clk(clk), .reset(reset), .WINNER(WINNER), .LOSER(LOSER), .GAMEOVER(GAMEOVER),
    .WHO(WHO), .count(count), .ack(ack), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_overflow(evt_overflow),
    .win_tally(win_tally), .lose_tally(lose_tally), .games_played(games_played),
    .last_who(last_who), .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WINNER = 0; LOSER = 0; GAMEOVER = 0; ack = 0; WHO = 2'b00;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  32'(evt_valid), 0);
    chk({tag, "_ovf"},    32'(evt_overflow), 0);
    chk({tag, "_win"},    32'(win_tally), 0);
    chk({tag, "_lose"},   32'(lose_tally), 0);
    chk({tag, "_games"},  32'(games_played), 0);
    chk({tag, "_who"},    32'(last_who), 0);
    chk({tag, "_result"}, 32'(result_valid), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    evt_ready = 0; count = 4'h0;
    reset = 1'b1;
    step(); step();
    chk_reset_vals("por");
    reset = 1'b0;

    // Three WINNER pulses at count=F, consumer always ready
    evt_ready = 1; count = 4'hF; WINNER = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("win_tally_ramp", 32'(win_tally), 32'(i));
      chk("win_evt_valid", 32'(evt_valid), 1);
      chk("win_evt_data", 32'(evt_data), 32'h1F);
    end
    WINNER = 0;
    step();
    chk("win_drained", 32'(evt_valid), 0);
    chk("win_tally_hold", 32'(win_tally), 3);

    // WINNER+LOSER together, then GAMEOVER with all three asserted
    do_reset();
    chk_reset_vals("rst2");
    evt_ready = 0; count = 4'h5; WINNER = 1; LOSER = 1;
    step();
    chk("both_win", 32'(win_tally), 1);
    chk("both_lose", 32'(lose_tally), 0);
    chk("both_evt", 32'(evt_data), 32'h15);
    GAMEOVER = 1; WHO = 2'b10;
    step();
    idle_inputs();
    chk("go_win", 32'(win_tally), 1);
    chk("go_lose", 32'(lose_tally), 0);
    chk("go_who", 32'(last_who), 2);
    chk("go_games", 32'(games_played), 1);
    chk("go_result", 32'(result_valid), 1);
    evt_ready = 1;
    step();
    chk("go_evt_data", 32'(evt_data), 32'h32);
    chk("go_evt_valid", 32'(evt_valid), 1);
    step();
    evt_ready = 0;
    chk("go_evt_empty", 32'(evt_valid), 0);

    // OVER ignores scoring inputs; ack returns to PLAY
    for (int i = 0; i < 5; i++) begin
      LOSER = 1; WINNER = i[0]; GAMEOVER = i[1]; WHO = 2'b01;
      step();
      chk("over_lose", 32'(lose_tally), 0);
      chk("over_win", 32'(win_tally), 1);
      chk("over_noevt", 32'(evt_valid), 0);
      chk("over_result", 32'(result_valid), 1);
    end
    idle_inputs();
    chk("over_games", 32'(games_played), 1);
    chk("over_who", 32'(last_who), 2);
    ack = 1;
    step();
    ack = 0;
    chk("ack_result", 32'(result_valid), 0);
    chk("ack_win", 32'(win_tally), 0);
    chk("ack_lose", 32'(lose_tally), 0);
    chk("ack_games", 32'(games_played), 1);
    chk("ack_who", 32'(last_who), 2);
    LOSER = 1; count = 4'h3;
    step();
    LOSER = 0;
    chk("play_lose", 32'(lose_tally), 1);
    chk("play_evt", 32'(evt_data), 32'h23);
    ack = 1;
    step();
    ack = 0;
    chk("ack_in_play_result", 32'(result_valid), 0);
    chk("ack_in_play_lose", 32'(lose_tally), 1);

    // Overflow: six pushes into a 4-deep FIFO with consumer stalled
    do_reset();
    evt_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      LOSER = 1; count = 4'(i);
      step();
    end
    LOSER = 0;
    chk("ovf_lose", 32'(lose_tally), 6);
    chk("ovf_flag", 32'(evt_overflow), 1);
    evt_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain_valid", 32'(evt_valid), 1);
      chk("ovf_drain_data", 32'(evt_data), 32'h20 + 32'(i));
      step();
    end
    chk("ovf_empty", 32'(evt_valid), 0);
    chk("ovf_sticky", 32'(evt_overflow), 1);
    evt_ready = 0;

    // Push and pop together on a full FIFO
    do_reset();
    for (int i = 7; i <= 10; i++) begin
      LOSER = 1; count = 4'(i);
      step();
    end
    chk("full_noovf", 32'(evt_overflow), 0);
    count = 4'hB; evt_ready = 1;
    step();
    LOSER = 0;
    chk("full_pp_ovf", 32'(evt_overflow), 0);
    for (int i = 8; i <= 11; i++) begin
      chk("full_pp_data", 32'(evt_data), 32'h20 + 32'(i));
      step();
    end
    chk("full_pp_empty", 32'(evt_valid), 0);

    // Tally saturation
    WINNER = 1; count = 4'h1;
    for (int i = 0; i < 260; i++) step();
    WINNER = 0;
    chk("win_saturate", 32'(win_tally), 255);
    chk("sat_noovf", 32'(evt_overflow), 0);

    // WHO=11 latched unchanged
    do_reset();
    evt_ready = 0; GAMEOVER = 1; WHO = 2'b11;
    step();
    idle_inputs();
    chk("who11_latch", 32'(last_who), 3);
    chk("who11_evt", 32'(evt_data), 32'h33);

    // Asynchronous reset mid-cycle in OVER with three events queued
    do_reset();
    count = 4'h9; WINNER = 1;
    step(); step();
    WINNER = 0; GAMEOVER = 1; WHO = 2'b01;
    step();
    idle_inputs();
    chk("pre_async_result", 32'(result_valid), 1);
    chk("pre_async_games", 32'(games_played), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    #1;
    reset = 1'b0;
    WINNER = 1; count = 4'h4;
    step();
    WINNER = 0;
    chk("post_rst_win", 32'(win_tally), 1);
    chk("post_rst_evt", 32'(evt_data), 32'h14);
    chk("post_rst_result", 32'(result_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
